// File: rtl/dsd_cic_decimator.sv
// N-stage CIC decimator turning a 1-bit DSD stream into signed PCM with a one-cycle valid strobe.
// Define DSD_CIC_SAT_EN for full-scale output with clamping; otherwise output is 6 dB down and unclamped.
module dsd_cic_decimator #(
  parameter int PCM_Bit_Length = 32,
  parameter int CIC_Order      = 4,
  parameter int Dec_Log2       = 6
) (
  input  logic                             BCLK_I,
  input  logic                             RESET_N_I,
  input  logic                             DSD_I,
  input  logic                             DSD_VALID_I,
  output logic signed [PCM_Bit_Length-1:0] PCM_O,
  output logic                             PCM_VALID_O
);

  localparam int P  = PCM_Bit_Length;
  localparam int N  = CIC_Order;
  localparam int D  = Dec_Log2;
  localparam int W  = N * D + 2;
  localparam int SW = $clog2(N + 1);

  logic [D-1:0]        cnt_reg;
  logic [N+1:0]        tok_reg;
  logic                frame_end;
  logic signed [W-1:0] step;
  logic signed [W-1:0] int_reg  [N];
  logic signed [W-1:0] cap_reg;
  logic signed [W-1:0] comb_in  [N];
  logic signed [W-1:0] comb_reg [N];
  logic signed [W-1:0] dly_reg  [N];
  logic signed [W-1:0] comb_out;
  logic [SW-1:0]       settle_reg;
  logic signed [P-1:0] pcm_reg;
  logic signed [P-1:0] pcm_next;
  logic                valid_reg;

  assign frame_end = DSD_VALID_I && (cnt_reg == {D{1'b1}});
  assign step      = DSD_I ? W'(1) : {W{1'b1}};

  // tok_reg[0]: capture I_N, tok_reg[k+1]: comb stage k, tok_reg[N+1]: output register
  always_ff @(posedge BCLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      cnt_reg <= '0;
      tok_reg <= '0;
    end else begin
      tok_reg <= {tok_reg[N:0], frame_end};
      if (DSD_VALID_I)
        cnt_reg <= cnt_reg + D'(1);
    end
  end

  always_ff @(posedge BCLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      for (int k = 0; k < N; k++)
        int_reg[k] <= '0;
    end else if (DSD_VALID_I) begin
      int_reg[0] <= int_reg[0] + step;
      for (int k = 1; k < N; k++)
        int_reg[k] <= int_reg[k] + int_reg[k-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_comb_in
    if (gi == 0) begin : g_first
      assign comb_in[gi] = cap_reg;
    end else begin : g_rest
      assign comb_in[gi] = comb_reg[gi-1];
    end
  end

  assign comb_out = comb_reg[N-1];

  always_ff @(posedge BCLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      cap_reg <= '0;
      for (int k = 0; k < N; k++) begin
        comb_reg[k] <= '0;
        dly_reg[k]  <= '0;
      end
    end else begin
      if (tok_reg[0])
        cap_reg <= int_reg[N-1];
      for (int k = 0; k < N; k++) begin
        if (tok_reg[k+1]) begin
          comb_reg[k] <= comb_in[k] - dly_reg[k];
          dly_reg[k]  <= comb_in[k];
        end
      end
    end
  end

`ifdef DSD_CIC_SAT_EN
  localparam int SH = P - 1 - N * D;
  localparam logic signed [W-1:0] FULL_SCALE = W'(1) << (N * D);

  // only +R^N can overflow after scaling; -R^N lands exactly on the most negative code
  always_comb begin
    pcm_next = P'(comb_out) <<< SH;
    if (comb_out >= FULL_SCALE)
      pcm_next = {1'b0, {(P-1){1'b1}}};
  end
`else
  localparam int SH = P - 2 - N * D;

  if (SH >= 0) begin : g_shl
    always_comb pcm_next = P'(comb_out) <<< SH;
  end else begin : g_shr
    always_comb pcm_next = P'(comb_out >>> (-SH));
  end
`endif

  always_ff @(posedge BCLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      pcm_reg    <= '0;
      valid_reg  <= 1'b0;
      settle_reg <= '0;
    end else if (tok_reg[N+1]) begin
      pcm_reg   <= pcm_next;
      valid_reg <= (settle_reg == SW'(N - 1));
      if (settle_reg != SW'(N - 1))
        settle_reg <= settle_reg + SW'(1);
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign PCM_O       = pcm_reg;
  assign PCM_VALID_O = valid_reg;

endmodule

// File: tb/tb_dsd_cic_decimator.sv
// Bench for dsd_cic_decimator: table of stream scenarios, scoreboard of expected strobes, reset corner case.
module tb_dsd_cic_decimator;

  localparam int R = 64;
  localparam int N = 4;
  localparam int HL = N * (R - 1) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               dsd = 1'b0;
  logic               dsd_valid = 1'b0;
  logic signed [31:0] pcm;
  logic               pcm_valid;

  dsd_cic_decimator dut (
    .BCLK_I      (clk),
    .RESET_N_I   (rst_n),
    .DSD_I       (dsd),
    .DSD_VALID_I (dsd_valid),
    .PCM_O       (pcm),
    .PCM_VALID_O (pcm_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  typedef struct {
    int          mode;     // 0 constant, 1 alternating, 2 random bits and gaps
    logic        bitval;
    int          period;
    int          frames;
    logic [31:0] exp_sat;
    logic [31:0] exp_nosat;
    int          spacing;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int spacing_exp = 0;
  int last_strobe = -1;
  logic prev_valid = 1'b0;
  bit mon_en = 1'b0;

  int samp_cnt;
  int frame_cnt;
  int xs[0:1023];
  int h[0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // direct-form reference: boxcar^N impulse response over the valid-sample history
  function automatic int model(input int n);
    int s = 0;
    for (int j = 0; j < HL; j++) begin
      int idx = n - (N - 1) - j;
      if (idx >= 0) s += h[j] * xs[idx];
    end
    return s;
  endfunction

  function automatic logic [31:0] scale(input int v);
`ifdef DSD_CIC_SAT_EN
    if (v >= (1 << 24)) return 32'h7FFF_FFFF;
    return 32'(v <<< 7);
`else
    return 32'(v <<< 6);
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en && pcm_valid) begin
      exp_t e;
      check("no_double_strobe", {31'b0, prev_valid}, 32'h0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        $display("strobe cyc=%0d pcm=%h exp=%h", cyc, pcm, e.val);
        check("pcm_value", pcm, e.val);
        check("strobe_cycle", cyc, e.due);
        if (spacing_exp > 0 && last_strobe >= 0)
          check("strobe_spacing", cyc - last_strobe, spacing_exp);
      end
      last_strobe = cyc;
    end
    prev_valid = pcm_valid;
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    dsd_valid = 1'b0;
    dsd = 1'b0;
    repeat (3) @(posedge clk);
    sb.delete();
    samp_cnt = 0;
    frame_cnt = 0;
    last_strobe = -1;
    #1 rst_n = 1'b1;
  endtask

  task automatic run_frames(input int mode, input logic bitval, input int period,
                            input int frames, input logic [31:0] exp_val);
    int   phase = 0;
    logic v;
    logic b;
    exp_t e;
    while (frame_cnt < frames) begin
      v = (mode == 2) ? 1'($urandom_range(0, 1)) : (phase == 0);
      phase = (phase + 1) % period;
      case (mode)
        0:       b = bitval;
        1:       b = (samp_cnt % 2 == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      dsd_valid = v;
      dsd = b;
      @(posedge clk);
      #1;
      if (v) begin
        xs[samp_cnt] = b ? 1 : -1;
        samp_cnt++;
        if (samp_cnt % R == 0) begin
          frame_cnt++;
          if (frame_cnt >= N) begin
            e.val = (mode == 2) ? scale(model(samp_cnt - 1)) : exp_val;
            e.due = cyc + N + 2;
            sb.push_back(e);
          end
        end
      end
    end
    dsd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (12) @(posedge clk);
    #1;
    check(name, sb.size(), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   tmp[0:255];
    int   len;
    logic [31:0] exp_full;

    vecs[0] = '{0, 1'b1, 1, 7, 32'h7FFF_FFFF, 32'h4000_0000, 64};
    vecs[1] = '{0, 1'b0, 1, 7, 32'h8000_0000, 32'hC000_0000, 64};
    vecs[2] = '{1, 1'b0, 1, 7, 32'h0000_0000, 32'h0000_0000, 64};
    vecs[3] = '{0, 1'b1, 3, 6, 32'h7FFF_FFFF, 32'h4000_0000, 192};
    vecs[4] = '{2, 1'b0, 1, 6, 32'h0,         32'h0,         0};

`ifdef DSD_CIC_SAT_EN
    exp_full = 32'h7FFF_FFFF;
`else
    exp_full = 32'h4000_0000;
`endif

    for (int i = 0; i < 256; i++) h[i] = (i < R) ? 1 : 0;
    len = R;
    for (int k = 1; k < N; k++) begin
      for (int i = 0; i < 256; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i + j] += h[i];
      h = tmp;
      len += R - 1;
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_pcm", pcm, 32'h0);
    check("reset_valid", {31'b0, pcm_valid}, 32'h0);
    mon_en = 1'b1;

    for (int r = 0; r < 5; r++) begin
      reset_dut();
      spacing_exp = vecs[r].spacing;
`ifdef DSD_CIC_SAT_EN
      run_frames(vecs[r].mode, vecs[r].bitval, vecs[r].period, vecs[r].frames, vecs[r].exp_sat);
`else
      run_frames(vecs[r].mode, vecs[r].bitval, vecs[r].period, vecs[r].frames, vecs[r].exp_nosat);
`endif
      drain($sformatf("drain_row%0d", r));
    end

    // reset two cycles after the frame-5 token issues, held for one cycle
    reset_dut();
    spacing_exp = R;
    run_frames(0, 1'b1, 1, 5, exp_full);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_pcm", pcm, exp_full);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pcm", pcm, 32'h0);
    check("async_reset_valid", {31'b0, pcm_valid}, 32'h0);
    sb.delete();
    samp_cnt = 0;
    frame_cnt = 0;
    last_strobe = -1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frames(0, 1'b1, 1, 6, exp_full);
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsd_cic_decimator.md
# dsd_cic_decimator

Converts a 1-bit DSD bitstream back into signed parallel PCM, the inverse of the delta-sigma PCM-to-DSD path. It uses an N-stage CIC (cascaded integrator-comb) decimation filter. Integrators run at the DSD bit rate and combs run at the decimated rate. The block sits at the DSD input side of the design and feeds the PCM datapath with a one-cycle valid strobe per output sample.

## Interface
- PCM_Bit_Length, 32, output PCM word width P.
- CIC_Order, 4, number of integrator and comb stages N (1..6).
- Dec_Log2, 6, log2 of the decimation ratio R (R = 2^Dec_Log2).
- Constraints:
  - P-1 >= N*Dec_Log2.
  - R > N+1.
- BCLK_I  input  1  bit clock; all state on rising edge.
- RESET_N_I  input  1  reset, asynchronous, active-low.
- DSD_I  input  1  DSD bit; 1 maps to +1, 0 maps to -1.
- DSD_VALID_I  input  1  DSD_I is sampled and consumed on this cycle.
- PCM_O  output  P (signed)  decimated PCM sample; held between strobes.
- PCM_VALID_O  output  1  one-cycle strobe, PCM_O is new this cycle.

## Operation
- Internal width W = N*Dec_Log2 + 2, two's complement, modular (wrap) arithmetic in integrators and combs. Wrap is intended; comb output is exact.
- Integrators:
  - On each DSD_VALID_I cycle: I1 += (DSD_I ? +1 : -1), then Ik += I(k-1) for k = 2..N, all registered in parallel (one-cycle skew per stage is inherent and accepted).
  - When DSD_VALID_I is low, integrators and counter hold.
- Decimation counter:
  - Dec_Log2 bits, increments per valid bit, wraps R-1 -> 0.
  - On the valid cycle where the counter equals R-1, a frame token is issued and I_N is captured into the comb pipeline the following cycle.
- Combs:
  - N registered stages, Ck = x - x_delayed(k), where the delay register is updated only when the token passes that stage.
  - The token advances one stage per BCLK_I regardless of DSD_VALID_I.
- Output scaling:
  - Comb result v lies in [-R^N, +R^N].
  - Scaling to P bits is set by DSD_CIC_SAT_EN; see Configuration.
- Settle:
  - A frame counter suppresses PCM_VALID_O for the first N-1 frames after reset, because those windows are partial.
  - PCM_O still updates during those frames.
  - The first strobe is frame N. The counter then saturates.
- Reset (asynchronous, including mid-frame or mid-pipeline):
  - Integrators, comb delays, token pipeline, decimation counter and settle counter all clear to 0.
  - PCM_O = 0 and PCM_VALID_O = 0 immediately.
  - Any in-flight token is discarded.

## Timing
- Latency: PCM_VALID_O asserts exactly N+2 BCLK_I cycles after the rising edge that consumed the R-th valid bit of a frame. This is one capture cycle, N comb stages and one output register.
- At most one token is in flight at a time; guaranteed by R > N+1 even with DSD_VALID_I high every cycle.
- Gaps in DSD_VALID_I stretch frames but do not affect an in-flight token.
- Simultaneous token issue and reset deassertion: a token issued on the first post-reset valid cycle is impossible, because the counter starts at 0.
- Output register updates only on the strobe cycle. Reset values: PCM_O = 0, PCM_VALID_O = 0.

## Configuration
- DSD_CIC_SAT_EN defined:
  - Full scale R^N maps to 2^(P-1): PCM_O = v << (P-1-N*Dec_Log2).
  - +R^N saturates to 2^(P-1)-1.
  - -R^N yields -2^(P-1) exactly.
- DSD_CIC_SAT_EN undefined:
  - PCM_O = v << (P-2-N*Dec_Log2), which is 6 dB attenuation.
  - No clamp logic is built, and overflow is impossible.

## Test plan
Defaults throughout: P = 32, N = 4, R = 64.
- Constant DSD_I=1, DSD_VALID_I=1 every cycle -> first PCM_VALID_O at frame 4. PCM_O = 32'h7FFFFFFF with SAT_EN, 32'h40000000 without. Value is stable each later frame.
- Constant DSD_I=0 -> PCM_O = 32'h80000000 with SAT_EN, 32'hC0000000 without, from frame 4 on.
- Alternating 1,0,1,0 from reset -> PCM_O = 0 on every strobe from frame 4 on. Strobes are spaced exactly 64 cycles apart.
- DSD_VALID_I high one cycle in three, DSD_I=1 -> strobes spaced 192 cycles apart, values identical to the first scenario. Each strobe occurs N+2 = 6 cycles after the 64th valid bit.
- Assert RESET_N_I low mid-pipeline, 2 cycles after a token issues -> PCM_O and PCM_VALID_O go to 0 asynchronously and no strobe appears for that token. After release, the first strobe is again at frame 4.
- Check that PCM_VALID_O is never high for two consecutive cycles.
- Check that no strobe appears in frames 1-3.
